// File: rtl/uart_wb_sequencer_if.sv
// Wishbone master port bundle between the UART sequencer and the UART register slave.
interface uart_wb_sequencer_if;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic [2:0]  ADR_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        ACK_I;

  modport master (output CYC_O, STB_O, WE_O, ADR_O, DAT_O, input DAT_I, ACK_I);
  modport slave  (input CYC_O, STB_O, WE_O, ADR_O, DAT_O, output DAT_I, ACK_I);
endinterface

// File: rtl/uart_wb_sequencer.sv
// Wishbone master that configures the UART after reset, then shuttles bytes between
// a TX producer stream, an RX consumer stream and the UART data registers.
module uart_wb_sequencer #(
  parameter logic [15:0] DIV_INIT = 16'h001F,
  parameter logic        NSTOP    = 1'b1,
  parameter logic [2:0]  TX_WM    = 3'd1,
  parameter logic [2:0]  RX_WM    = 3'd0,
  parameter logic [1:0]  IE_MASK  = 2'b11,
  parameter int          TIMEOUT  = 255
) (
  input  logic                       CLK_I,
  input  logic                       RST_I,
  uart_wb_sequencer_if.master        wb,
  input  logic [7:0]                 tx_byte,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [7:0]                 rx_byte,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic                       cfg_done,
  output logic                       bus_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] ADDR_TXDATA = 3'd0;
  localparam logic [2:0] ADDR_RXDATA = 3'd1;
  localparam logic [2:0] ADDR_TXCTRL = 3'd2;
  localparam logic [2:0] ADDR_RXCTRL = 3'd3;
  localparam logic [2:0] ADDR_IE     = 3'd4;
  localparam logic [2:0] ADDR_DIV    = 3'd6;

  typedef enum logic [3:0] {
    CfgRx, CfgTx, CfgIe, CfgDiv, Idle, TxPoll, TxWrite, RxRead, Gap
  } state_e;

  state_e        state_q, state_d;
  state_e        ret_q, ret_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [2:0]    adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ptr_q, ptr_d;
  logic          tx_ready_q, tx_ready_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          cfg_done_q, cfg_done_d;
  logic          bus_err_q, bus_err_d;

  logic          tx_cand, rx_cand;
  logic          arb_go;
  state_e        arb_st;
  logic          launch;
  state_e        launch_st;
  logic          end_access;
  logic [22:0]   unused_dat;

  assign unused_dat = wb.DAT_I[30:8];

  // TX is masked while tx_ready is high: the producer's byte is being consumed on that edge.
  assign tx_cand = tx_valid && !tx_ready_q;
  assign rx_cand = !rx_valid_q;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    tmo_d      = tmo_q;
    ptr_d      = ptr_q;
    tx_ready_d = 1'b0;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    cfg_done_d = cfg_done_q;
    bus_err_d  = bus_err_q;
    launch     = 1'b0;
    launch_st  = state_q;
    end_access = 1'b0;
    arb_go     = 1'b0;
    arb_st     = RxRead;

    if (tx_cand && (!rx_cand || !ptr_q)) begin
      arb_go = 1'b1;
      arb_st = TxPoll;
    end else if (rx_cand) begin
      arb_go = 1'b1;
      arb_st = RxRead;
    end

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      Idle, Gap: begin
        if (state_q == Gap && ret_q != Idle) begin
          launch    = 1'b1;
          launch_st = ret_q;
        end else if (arb_go) begin
          launch    = 1'b1;
          launch_st = arb_st;
          ptr_d     = ~ptr_q;
        end else begin
          state_d = Idle;
        end
      end
      default: begin
        // An access state with STB low only occurs right after reset release.
        if (!stb_q) begin
          launch    = 1'b1;
          launch_st = state_q;
        end else if (wb.ACK_I) begin
          end_access = 1'b1;
          case (state_q)
            CfgRx:   ret_d = CfgTx;
            CfgTx:   ret_d = CfgIe;
            CfgIe:   ret_d = CfgDiv;
            CfgDiv: begin
              ret_d      = Idle;
              cfg_done_d = 1'b1;
            end
            TxPoll:  ret_d = wb.DAT_I[31] ? Idle : TxWrite;
            TxWrite: begin
              ret_d      = Idle;
              tx_ready_d = 1'b1;
            end
            RxRead: begin
              ret_d = Idle;
              if (!wb.DAT_I[31]) begin
                rx_byte_d  = wb.DAT_I[7:0];
                rx_valid_d = 1'b1;
              end
            end
            default: ret_d = Idle;
          endcase
        end else if (tmo_q == TMO_LAST) begin
          end_access = 1'b1;
          bus_err_d  = 1'b1;
          ret_d      = (state_q inside {CfgRx, CfgTx, CfgIe, CfgDiv}) ? state_q : Idle;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
    endcase

    if (end_access) begin
      state_d = Gap;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      we_d    = 1'b0;
      tmo_d   = '0;
    end

    if (launch) begin
      state_d = launch_st;
      cyc_d   = 1'b1;
      stb_d   = 1'b1;
      tmo_d   = '0;
      case (launch_st)
        CfgRx: begin
          adr_d = ADDR_RXCTRL; we_d = 1'b1;
          dat_d = {13'b0, RX_WM, 15'b0, 1'b1};
        end
        CfgTx: begin
          adr_d = ADDR_TXCTRL; we_d = 1'b1;
          dat_d = {13'b0, TX_WM, 14'b0, NSTOP, 1'b1};
        end
        CfgIe: begin
          adr_d = ADDR_IE; we_d = 1'b1;
          dat_d = {30'b0, IE_MASK};
        end
        CfgDiv: begin
          adr_d = ADDR_DIV; we_d = 1'b1;
          dat_d = {16'b0, DIV_INIT};
        end
        TxPoll: begin
          adr_d = ADDR_TXDATA; we_d = 1'b0; dat_d = '0;
        end
        TxWrite: begin
          adr_d = ADDR_TXDATA; we_d = 1'b1;
          dat_d = {24'b0, tx_byte};
        end
        RxRead: begin
          adr_d = ADDR_RXDATA; we_d = 1'b0; dat_d = '0;
        end
        default: begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q    <= CfgRx;
      ret_q      <= CfgRx;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      tmo_q      <= '0;
      ptr_q      <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      cfg_done_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      tmo_q      <= tmo_d;
      ptr_q      <= ptr_d;
      tx_ready_q <= tx_ready_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      cfg_done_q <= cfg_done_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign wb.CYC_O = cyc_q;
  assign wb.STB_O = stb_q;
  assign wb.WE_O  = we_q;
  assign wb.ADR_O = adr_q;
  assign wb.DAT_O = dat_q;
  assign tx_ready = tx_ready_q;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign cfg_done = cfg_done_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_uart_wb_sequencer.sv
// Bench for uart_wb_sequencer: a small UART register slave model plus queues of expected
// bus writes and received bytes, driven by directed steps in one initial block.
module tb_uart_wb_sequencer;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready;
  logic       cfg_done;
  logic       bus_err;

  uart_wb_sequencer_if wb_if ();

  uart_wb_sequencer dut (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .wb       (wb_if),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .cfg_done (cfg_done),
    .bus_err  (bus_err)
  );

  always #5 CLK_I = ~CLK_I;

  int n_vec = 0;
  int n_err = 0;

  // Slave model: zero-wait ACK when enabled, TX "full" for a programmed number of polls,
  // and an RX FIFO the bench fills from the stimulus side.
  logic       ack_en = 1'b0;
  int         full_target = 0;
  int         full_done = 0;
  logic [7:0] rx_mem [16];
  int         rx_wr = 0;
  int         rx_rd = 0;
  logic       full;

  assign full = (full_done < full_target);
  assign wb_if.ACK_I = wb_if.CYC_O & wb_if.STB_O & ack_en;

  always_comb begin
    wb_if.DAT_I = 32'h0;
    if (wb_if.ADR_O == 3'd0)
      wb_if.DAT_I = {full, 31'h0};
    else if (wb_if.ADR_O == 3'd1)
      wb_if.DAT_I = (rx_rd == rx_wr) ? 32'h8000_0000 : {24'h0, rx_mem[rx_rd % 16]};
  end

  always @(posedge CLK_I) begin
    if (wb_if.ACK_I && !wb_if.WE_O) begin
      if (wb_if.ADR_O == 3'd0 && full) full_done <= full_done + 1;
      if (wb_if.ADR_O == 3'd1 && rx_rd != rx_wr) rx_rd <= rx_rd + 1;
    end
  end

  logic [34:0] wr_q [$];
  logic [7:0]  rx_exp [$];
  bit          turn_log [$];
  int          full_polls = 0;
  logic        prev_ack = 1'b0;
  logic        prev_wr0 = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Monitor: pops expected writes/bytes as the DUT completes them, and checks the
  // one-cycle gap, the tx_ready pulse and the no-read-while-occupied rule.
  always @(negedge CLK_I) begin
    logic [34:0] exp_wr;
    logic        acked;
    if (!RST_I) begin
      prev_ack = 1'b0;
      prev_wr0 = 1'b0;
    end else begin
      acked = wb_if.CYC_O & wb_if.STB_O & wb_if.ACK_I;
      if (prev_ack) checkOutput("gap_stb", {62'b0, wb_if.CYC_O, wb_if.STB_O}, 64'd0);
      checkOutput("tx_ready_pulse", {63'b0, tx_ready}, {63'b0, prev_wr0});
      if (acked) begin
        if (wb_if.WE_O) begin
          checkOutput("wr_pending", {63'b0, wr_q.size() > 0}, 64'd1);
          if (wr_q.size() > 0) begin
            exp_wr = wr_q.pop_front();
            checkOutput("wr_data", {29'b0, wb_if.ADR_O, wb_if.DAT_O}, {29'b0, exp_wr});
          end
        end else if (wb_if.ADR_O == 3'd1) begin
          checkOutput("rx_gate", {63'b0, rx_valid}, 64'd0);
          turn_log.push_back(1'b1);
        end else begin
          checkOutput("rd_addr", {61'b0, wb_if.ADR_O}, 64'd0);
          turn_log.push_back(1'b0);
          if (full) full_polls++;
        end
      end
      if (rx_valid && rx_ready) begin
        checkOutput("rx_pending", {63'b0, rx_exp.size() > 0}, 64'd1);
        if (rx_exp.size() > 0) checkOutput("rx_byte", {56'b0, rx_byte}, {56'b0, rx_exp.pop_front()});
      end
      prev_ack = acked;
      prev_wr0 = acked & wb_if.WE_O & (wb_if.ADR_O == 3'd0);
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    int n;
    n = 0;
    wr_q.push_back({3'd0, 24'd0, b});
    tx_byte  = b;
    tx_valid = 1'b1;
    @(negedge CLK_I);
    while (!tx_ready && n < 300) begin
      @(negedge CLK_I);
      n++;
    end
    checkOutput("tx_handshake", {63'b0, tx_ready}, 64'd1);
    @(posedge CLK_I);
    #1;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (wr_q.size() != 0 && n < 300) begin
      @(negedge CLK_I);
      n++;
    end
    checkOutput("wr_drain", {32'b0, wr_q.size()}, 64'd0);
  endtask

  initial begin
    int n;
    int hi;
    int p0;
    int first;
    tx_byte  = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;

    // Asynchronous reset before any clock edge.
    #1 RST_I = 1'b0;
    #1;
    checkOutput("reset_outputs",
                {14'b0, wb_if.CYC_O, wb_if.STB_O, wb_if.WE_O, wb_if.ADR_O, wb_if.DAT_O,
                 tx_ready, rx_valid, rx_byte, cfg_done, bus_err}, 64'd0);

    // Slave never acknowledges: CfgRx must time out after 255 cycles and be retried.
    repeat (2) @(posedge CLK_I);
    #1 RST_I = 1'b1;
    n = 0;
    @(negedge CLK_I);
    while (!wb_if.STB_O && n < 10) begin
      @(negedge CLK_I);
      n++;
    end
    hi = 0;
    while (wb_if.STB_O && hi < 400) begin
      @(negedge CLK_I);
      hi++;
    end
    checkOutput("timeout_len", 64'(hi), 64'd255);
    checkOutput("timeout_bus_err", {63'b0, bus_err}, 64'd1);
    @(negedge CLK_I);
    checkOutput("timeout_retry", {60'b0, wb_if.STB_O, wb_if.ADR_O}, {60'b0, 1'b1, 3'd3});

    // Reset in the middle of the retried access.
    @(posedge CLK_I);
    #3 RST_I = 1'b0;
    #1;
    checkOutput("async_reset", {61'b0, wb_if.CYC_O, wb_if.STB_O, bus_err}, 64'd0);

    // Configuration with a zero-wait slave.
    wr_q.push_back({3'd3, 32'h0000_0001});
    wr_q.push_back({3'd2, 32'h0001_0003});
    wr_q.push_back({3'd4, 32'h0000_0003});
    wr_q.push_back({3'd6, 32'h0000_001F});
    ack_en = 1'b1;
    repeat (2) @(posedge CLK_I);
    #1 RST_I = 1'b1;
    @(negedge CLK_I);
    checkOutput("first_access_delay", {63'b0, wb_if.CYC_O}, 64'd0);
    repeat (7) @(posedge CLK_I);
    @(negedge CLK_I);
    checkOutput("cfg_done_early", {63'b0, cfg_done}, 64'd0);
    @(negedge CLK_I);
    checkOutput("cfg_done", {63'b0, cfg_done}, 64'd1);
    checkOutput("cfg_wr_count", {32'b0, wr_q.size()}, 64'd0);
    @(posedge CLK_I);
    #1;

    // TX normal.
    applyStimulus(8'hA5);
    tx_valid = 1'b0;
    waitDrain();

    // TX with the UART FIFO full for three polls.
    p0 = full_polls;
    full_target = full_done + 3;
    applyStimulus(8'h5A);
    tx_valid = 1'b0;
    waitDrain();
    checkOutput("tx_full_polls", 64'(full_polls - p0), 64'd3);

    // RX capture held by backpressure.
    rx_mem[rx_wr % 16] = 8'h3C;
    rx_exp.push_back(8'h3C);
    rx_wr++;
    n = 0;
    while (!rx_valid && n < 50) begin
      @(negedge CLK_I);
      n++;
    end
    checkOutput("rx_capture", {55'b0, rx_valid, rx_byte}, {55'b0, 1'b1, 8'h3C});
    rx_mem[rx_wr % 16] = 8'h77;
    rx_exp.push_back(8'h77);
    rx_wr++;
    repeat (20) @(negedge CLK_I);
    checkOutput("rx_hold", {55'b0, rx_valid, rx_byte}, {55'b0, 1'b1, 8'h3C});
    checkOutput("rx_fifo_kept", 64'(rx_wr - rx_rd), 64'd1);
    @(posedge CLK_I);
    #1 rx_ready = 1'b1;
    @(negedge CLK_I);
    @(negedge CLK_I);
    checkOutput("rx_drop", {63'b0, rx_valid}, 64'd0);
    n = 0;
    while (rx_exp.size() != 0 && n < 50) begin
      @(negedge CLK_I);
      n++;
    end
    checkOutput("rx_drain", {32'b0, rx_exp.size()}, 64'd0);

    // Arbitration with both sides continuously eligible.
    @(posedge CLK_I);
    #1;
    turn_log.delete();
    for (int i = 0; i < 5; i++) applyStimulus(8'h10 + 8'(i));
    tx_valid = 1'b0;
    repeat (10) @(posedge CLK_I);
    #1;
    first = -1;
    for (int i = 0; i < turn_log.size(); i++) begin
      if (first < 0 && turn_log[i] == 1'b0) first = i;
    end
    checkOutput("arb_len", {63'b0, (first >= 0) && (turn_log.size() >= first + 8)}, 64'd1);
    if (first >= 0 && turn_log.size() >= first + 8) begin
      for (int i = 0; i < 8; i++)
        checkOutput("arb_turn", {63'b0, turn_log[first + i]}, {63'b0, 1'(i % 2)});
    end
    waitDrain();
    checkOutput("bus_err_clean", {63'b0, bus_err}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_wb_sequencer.md
# uart_wb_sequencer

Wishbone bus master that owns the UART peripheral's register port. After reset it writes the receive-control, transmit-control, interrupt-enable and baud-divisor registers. It then moves bytes between two valid/ready byte streams and the UART's txdata/rxdata registers, alternating service between TX and RX. It sits between a processor-side byte producer/consumer and the `uart` slave, so the core never has to poll UART registers itself.

## Interface
- `DIV_INIT`, 16'h001F: value written to div[15:0].
- `NSTOP`, 1'b1: txctrl bit 1 (1 = two stop bits).
- `TX_WM`, 3'd1: txctrl[18:16] watermark.
- `RX_WM`, 3'd0: rxctrl[18:16] watermark.
- `IE_MASK`, 2'b11: ie[1:0] value.
- `TIMEOUT`, 255: maximum cycles with STB_O high and no ACK_I before the access is aborted (≥2).

Ports:
- `CLK_I` in 1: the only clock.
- `RST_I` in 1: reset, asynchronous and active-low.
- `CYC_O` out 1, `STB_O` out 1, `WE_O` out 1: Wishbone master strobes.
- `ADR_O` out 3: UART word address (0 txdata, 1 rxdata, 2 txctrl, 3 rxctrl, 4 ie, 6 div).
- `DAT_O` out 32: write data.
- `DAT_I` in 32: read data. Bit 31 = full (addr 0) or empty (addr 1); [7:0] = rx byte.
- `ACK_I` in 1: slave acknowledge.
- `tx_byte` in 8, `tx_valid` in 1, `tx_ready` out 1: byte to transmit.
- `rx_byte` out 8, `rx_valid` out 1, `rx_ready` in 1: received byte.
- `cfg_done` out 1: configuration complete (sticky until reset).
- `bus_err` out 1: sticky flag, set on any timeout.

## Operation
- **Reset** (RST_I=0, async): all outputs 0, state CfgRx, round-robin pointer = TX, timeout counter 0. Reset mid-access drops CYC_O/STB_O immediately.
- **States:** CfgRx → CfgTx → CfgIe → CfgDiv → Idle; TxPoll, TxWrite, RxRead; Gap.
- **Config writes** (WE_O=1), in order:
  - CfgRx: addr 3, DAT_O = {13'b0, RX_WM, 15'b0, 1'b1}.
  - CfgTx: addr 2, DAT_O = {13'b0, TX_WM, 14'b0, NSTOP, 1'b1}.
  - CfgIe: addr 4, DAT_O = {30'b0, IE_MASK}.
  - CfgDiv: addr 6, DAT_O = {16'b0, DIV_INIT}.
  - cfg_done rises the cycle after the CfgDiv ACK.
- **Idle arbitration:**
  - TX candidate: tx_valid=1. RX candidate: rx_valid=0, i.e. the holding register is free.
  - If both are candidates, the pointer picks; the pointer toggles after every serviced turn.
  - If only one is a candidate, it is taken. If neither, stay in Idle.
- **TX turn:**
  - TxPoll reads addr 0. If DAT_I[31]=1 (full), the turn ends with the byte kept and tx_ready not pulsed.
  - Otherwise go to TxWrite: addr 0, WE_O=1, DAT_O = {24'b0, tx_byte}.
  - tx_ready pulses for exactly 1 cycle, the cycle after the TxWrite ACK.
  - The producer must hold tx_byte/tx_valid stable from tx_valid rise until tx_ready.
- **RX turn:**
  - RxRead reads addr 1 (this pops the UART FIFO).
  - If DAT_I[31]=0: rx_byte ← DAT_I[7:0] and rx_valid ← 1, both visible the cycle after ACK.
  - If DAT_I[31]=1 (empty): nothing is captured.
- **RX holding register:** rx_valid clears on the edge where rx_valid & rx_ready. rx_byte holds its value until the next capture.
- **No read while occupied:** no RxRead is issued while rx_valid=1, so no byte is ever lost.
- **Timeout:**
  - The counter runs while STB_O=1 and ACK_I=0. When it reaches TIMEOUT, the access aborts and bus_err ← 1.
  - Config step: the same step is retried.
  - TX: the byte is not consumed.
  - RX: treated as empty.

## Timing
- **Registered outputs:** all outputs are registered. CYC_O, STB_O, ADR_O, WE_O and DAT_O become valid in the first cycle of an access state and are held constant until the ACK edge.
- **ACK_I:** sampled on the rising CLK_I edge. An access ends on the edge where ACK_I=1; a same-cycle ACK (1-cycle access) is legal.
- **Gap:** after every ACK or abort, CYC_O=STB_O=0 for exactly 1 cycle (Gap state), then the next state begins.
- **Configuration latency:** with a zero-wait slave, the first access starts 1 cycle after reset release, and the 4 writes plus gaps take 8 cycles.
- **TX latency:** with a zero-wait slave, a full TX turn (poll, gap, write, gap) is 4 cycles.
- **RX latency:** with a zero-wait slave, an RX turn is 2 cycles.
- **Simultaneous events:** an rx_ready consumption and a new RxRead ACK cannot coincide, because the read is gated by rx_valid=0. A tx_valid drop without tx_ready is a protocol violation and its behaviour is undefined.
- **DAT_I:** only sampled on ACK edges of read accesses.

## Test plan
- **Config sequence:** release reset with a zero-wait slave → writes addr 3 = 0x0000_0001, addr 2 = 0x0001_0003, addr 4 = 0x3, addr 6 = 0x1F, in that order. cfg_done=1 at cycle 9; each write is followed by 1 idle cycle.
- **TX normal:** tx_byte=0xA5, tx_valid=1, slave returns DAT_I[31]=0 → read addr 0, then write addr 0 with DAT_O=0xA5. tx_ready is a 1-cycle pulse after the write ACK.
- **TX full:** slave returns DAT_I[31]=1 on 3 polls, then 0 → no write and no tx_ready during the full polls. Exactly one write of the byte occurs after the first non-full poll.
- **RX capture with backpressure:** DAT_I = 0x0000_003C (not empty), rx_ready=0 → rx_valid=1 and rx_byte=0x3C. No further addr-1 read occurs until rx_ready=1, and rx_valid drops on that edge.
- **Arbitration:** tx_valid=1 and the RX holding register free, continuously → turns alternate TX, RX, TX, RX…, verified over 8 turns.
- **Timeout and reset:**
  - Slave never ACKs CfgRx → STB_O drops after 255 cycles, bus_err=1, and CfgRx is retried.
  - Asserting RST_I low mid-access → CYC_O=0 asynchronously and bus_err=0.
